wishbone_timer_slave: RTL and testbench
=======================================

# wishbone_timer_slave

Wishbone responder holding a 32-bit programmable timer/compare unit with a level interrupt. It decodes the slave strobe at port 0xB of the system Wishbone interconnect (address bits [31:28] = 4'hB) and is the responder end of the core's Wishbone initiator port. Its interrupt drives core input i_MEI_1. Register access uses the same single-cycle registered-ACK handshake as the other system slaves.

## Interface
Parameters:
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- ADDR_WIDTH, 32, bus address width; only bits [4:2] are decoded.

Ports:
- i_CLK  in  1  system clock.
- i_RSTn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_ADDR  in  ADDR_WIDTH  byte address, with the upper nibble already zeroed by the interconnect.
- i_DATA  in  32  write data.
- o_DATA  out  32  read data.
- i_WE  in  1  1 = write, 0 = read.
- i_SEL  in  4  byte-lane enables for writes.
- i_STB  in  1  strobe, gated by the interconnect.
- o_ACK  out  1  transfer acknowledge.
- i_CYC  in  1  bus cycle valid.
- i_TAGN  in  1  master tag.
- o_TAGN  out  1  tag returned alongside ACK.
- o_IRQ  out  1  level interrupt to the core.

## Operation
Register map (offset = i_ADDR[4:2]×4):
- 0x00 CTRL: bit0 EN (enable), bit1 IE (interrupt enable), bit2 MODE (0 = free-run, 1 = auto-clear on match). Bits [31:3] read 0.
- 0x04 PRESCALE[15:0]: one tick every PRESCALE+1 clocks. Bits [31:16] read 0.
- 0x08 COUNT[31:0]: read/write.
- 0x0C COMPARE[31:0]: read/write.
- 0x10 STATUS: bit0 MATCH; writing 1 clears it (W1C).
- Offsets 0x14–0x1C: reads return 0, writes are ignored, the transfer is still ACKed.

Counting:
- The prescaler counter increments while EN = 1. When it equals PRESCALE it generates a tick and reloads 0. EN = 0 holds it at 0.
- On a tick:
  - If COUNT == COMPARE: MATCH ← 1, and COUNT ← (MODE ? 0 : COUNT+1).
  - Otherwise COUNT ← COUNT+1.
  - Increment wraps 0xFFFFFFFF → 0 with no flag.
- o_IRQ = MATCH & IE, driven from registers with no combinational path from bus inputs.

Writes:
- Applied per byte lane per i_SEL.
- Take effect at the clock edge where o_ACK rises.

Simultaneous events:
- Bus write to COUNT in the same cycle as a tick: the written value wins and no increment occurs.
- MATCH set and W1C in the same cycle: set wins.
- Writing CTRL with EN 1→0 clears the prescaler counter that cycle. COUNT is held.
- Writing PRESCALE while running: the new value applies from the next comparison. If the prescaler counter already exceeds the new PRESCALE, it counts up and wraps through 0xFFFF before the next tick.

Reset (i_RSTn low, asynchronous): every register and the prescaler counter go to 0. o_ACK = 0, o_DATA = 0, o_TAGN = 0, o_IRQ = 0. An in-flight transfer is dropped without an ACK.

## Timing
- Request sampled when i_CYC & i_STB & ~o_ACK. On the next edge o_ACK = 1 for exactly one cycle.
- The master holds STB until it sees ACK. The earliest back-to-back request is sampled in the cycle after ACK falls, so a transfer takes 2 cycles.
- o_DATA is registered: valid only while o_ACK = 1, and 0 otherwise. A read returns the pre-write state of the same cycle.
- o_TAGN is captured from i_TAGN on the ACK edge.
- i_STB dropped before ACK: the ACK is still issued (registered). The master must not abort.
- Counting latency: with PRESCALE = P, EN written at edge t, the first COUNT increment occurs at edge t+P+1.
- MATCH and o_IRQ rise at the same edge, on the tick where COUNT == COMPARE.

## Structure
- Package `timer_pkg`: register offsets; CTRL bit indices EN/IE/MODE; STATUS_MATCH bit; PRESCALE width (16).
- Sub-module `timer_prescaler`:
  - Inputs: i_CLK, i_RSTn, i_EN, i_PRESCALE[15:0].
  - Output: o_TICK.
- The top level contains the bus decode, register file, COUNT/compare logic and the ACK register.

## Test plan
- Reset mid-transfer: assert i_RSTn low while o_ACK is high → all outputs 0 immediately; reading COUNT after release returns 0.
- Register access: write COMPARE = 0xDEADBEEF with SEL = 4'b0101 over the reset value → read returns 0x00AD00EF. ACK is one cycle, exactly one cycle after STB.
- Periodic interrupt: PRESCALE = 0, COMPARE = 4, CTRL = 0x7 → MATCH/o_IRQ at the 5th tick. COUNT sequence is 0,1,2,3,4,0; writing STATUS = 1 drops o_IRQ next cycle.
- Prescale: PRESCALE = 3, MODE = 0 → COUNT increments every 4 clocks; COUNT = 0xFFFFFFFF wraps to 0 with no MATCH if COMPARE ≠ 0xFFFFFFFF.
- Collisions:
  - Write COUNT = 0x100 on a tick cycle → read 0x100, not 0x101.
  - W1C on a match cycle → MATCH remains 1.
- Unmapped offset 0x18: read → 0 with ACK; write → no register changes; o_TAGN mirrors i_TAGN = 1.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the Wishbone timer/compare slave:
//   - register word indices (i_ADDR[4:2]) and byte offsets
//   - CTRL / STATUS bit positions
//   - prescaler width
//   - byte-lane merge helper used by the register file
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int PRESCALE_W = 16;
  localparam int LANES      = 4;

  // Word index of each register, as decoded from i_ADDR[4:2].
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT    = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_STATUS   = 3'd4
  } reg_idx_e;

  // Byte offsets matching the word indices above.
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // CTRL bits
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_W    = 3;

  // STATUS bits
  localparam int STATUS_MATCH = 0;

  // Replace the bytes of old_val selected by mask with those of new_val.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock down to a one-cycle tick every PRESCALE+1 clocks while
// enabled. Disabling holds the internal counter at 0, so the first tick after
// enabling arrives exactly PRESCALE+1 clocks later.
// Ports:
//   i_CLK       system clock
//   i_RSTn      asynchronous active-low reset
//   i_EN        count enable (0 clears the counter)
//   i_PRESCALE  terminal count; a tick is produced when the counter equals it
//   o_TICK      one-cycle tick, decoded from registered state only
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_EN,
  input  logic [PRESCALE_W-1:0] i_PRESCALE,
  output logic                  o_TICK
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt_reg;
  logic [PRESCALE_W-1:0] cnt_next;

  // A lowered PRESCALE that is already below cnt_reg is not caught here on
  // purpose: the counter runs on and wraps through 0xFFFF before the next match.
  always_comb begin
    o_TICK   = 1'b0;
    cnt_next = cnt_reg;
    if (!i_EN) begin
      cnt_next = '0;
    end else if (cnt_reg == i_PRESCALE) begin
      o_TICK   = 1'b1;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + ONE;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/wishbone_timer_slave.sv
// -----------------------------------------------------------------------------
// wishbone_timer_slave
// Wishbone responder with a 32-bit programmable timer/compare unit and a level
// interrupt. Single-cycle registered ACK: a request seen while o_ACK is low is
// acknowledged on the next edge, and any write lands on that same edge.
// Ports:
//   i_CLK, i_RSTn   clock, asynchronous active-low reset
//   i_ADDR          byte address; only [4:2] decoded
//   i_DATA/o_DATA   write data / registered read data (0 when not ACKing)
//   i_WE, i_SEL     write enable, byte-lane enables
//   i_STB, i_CYC    strobe and cycle valid
//   o_ACK           one-cycle acknowledge
//   i_TAGN/o_TAGN   master tag, returned with the ACK
//   o_IRQ           MATCH & IE, registered
// -----------------------------------------------------------------------------
module wishbone_timer_slave
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // only 32 is supported
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  output logic [DATA_WIDTH-1:0] o_DATA,
  input  logic                  i_WE,
  input  logic [LANES-1:0]      i_SEL,
  input  logic                  i_STB,
  output logic                  o_ACK,
  input  logic                  i_CYC,
  input  logic                  i_TAGN,
  output logic                  o_TAGN,
  output logic                  o_IRQ
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0]     ctrl_reg,     ctrl_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [31:0]           count_reg,    count_next;
  logic [31:0]           compare_reg,  compare_next;
  logic                  match_reg,    match_next;
  logic                  irq_reg,      irq_next;
  logic                  ack_reg;
  logic [31:0]           data_reg,     data_next;
  logic                  tagn_reg;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        req;
  logic        wr;
  logic [2:0]  reg_idx;
  logic [31:0] lane_mask;
  logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic        w1c_match;
  logic        unused_addr;

  assign req     = i_CYC & i_STB & ~ack_reg;
  assign wr      = req & i_WE;
  assign reg_idx = i_ADDR[4:2];

  // Address bits outside [4:2] carry no meaning for this slave.
  assign unused_addr = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{i_SEL[gi]}};
    end
  endgenerate

  assign wr_ctrl     = wr && (reg_idx == REG_CTRL);
  assign wr_prescale = wr && (reg_idx == REG_PRESCALE);
  assign wr_count    = wr && (reg_idx == REG_COUNT);
  assign wr_compare  = wr && (reg_idx == REG_COMPARE);
  assign wr_status   = wr && (reg_idx == REG_STATUS);
  assign w1c_match   = wr_status & i_SEL[0] & i_DATA[STATUS_MATCH];

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick;
  logic prescale_en;

  // Gating with ctrl_next as well makes an EN 1->0 write clear the prescaler
  // on the write edge itself and suppresses any tick there, so COUNT holds.
  assign prescale_en = ctrl_reg[CTRL_EN] & ctrl_next[CTRL_EN];

  timer_prescaler u_prescaler (
    .i_CLK      (i_CLK),
    .i_RSTn     (i_RSTn),
    .i_EN       (prescale_en),
    .i_PRESCALE (prescale_reg),
    .o_TICK     (tick)
  );

  // ---------------------------------------------------------------------------
  // Register file and timer
  // ---------------------------------------------------------------------------
  logic hit;
  assign hit = tick && (count_reg == compare_reg);

  always_comb begin
    ctrl_next = ctrl_reg;
    if (wr_ctrl && i_SEL[0]) begin
      ctrl_next = i_DATA[CTRL_W-1:0];
    end

    prescale_next = prescale_reg;
    if (wr_prescale) begin
      prescale_next = (prescale_reg & ~lane_mask[PRESCALE_W-1:0]) |
                      (i_DATA[PRESCALE_W-1:0] & lane_mask[PRESCALE_W-1:0]);
    end

    compare_next = compare_reg;
    if (wr_compare) begin
      compare_next = lane_merge(compare_reg, i_DATA, lane_mask);
    end

    // A bus write to COUNT overrides the tick, including its increment.
    count_next = count_reg;
    if (wr_count) begin
      count_next = lane_merge(count_reg, i_DATA, lane_mask);
    end else if (tick) begin
      if (hit && ctrl_reg[CTRL_MODE]) begin
        count_next = '0;
      end else begin
        count_next = count_reg + 32'd1;
      end
    end

    // A new match beats a same-cycle clear.
    match_next = match_reg;
    if (w1c_match) begin
      match_next = 1'b0;
    end
    if (hit) begin
      match_next = 1'b1;
    end

    irq_next = match_next & ctrl_next[CTRL_IE];
  end

  // Read mux: reads return the state before this cycle's write.
  always_comb begin
    data_next = '0;
    if (req && !i_WE) begin
      case (reg_idx)
        REG_CTRL:     data_next = {{(32-CTRL_W){1'b0}}, ctrl_reg};
        REG_PRESCALE: data_next = {{(32-PRESCALE_W){1'b0}}, prescale_reg};
        REG_COUNT:    data_next = count_reg;
        REG_COMPARE:  data_next = compare_reg;
        REG_STATUS:   data_next = {31'd0, match_reg};
        default:      data_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      count_reg    <= '0;
      compare_reg  <= '0;
      match_reg    <= 1'b0;
      irq_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      data_reg     <= '0;
      tagn_reg     <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      match_reg    <= match_next;
      irq_reg      <= irq_next;
      ack_reg      <= req;
      data_reg     <= data_next;
      if (req) begin
        tagn_reg <= i_TAGN;
      end
    end
  end

  assign o_ACK  = ack_reg;
  assign o_DATA = data_reg;
  assign o_TAGN = tagn_reg;
  assign o_IRQ  = irq_reg;

endmodule

// File: tb/tb_wishbone_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_wishbone_timer_slave
// Directed bench. The stimulus process issues bus transfers and pushes the
// expected response into a scoreboard queue; a monitor on the falling edge pops
// and compares whenever o_ACK is high. Interrupt and handshake timing are
// checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_wishbone_timer_slave;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_PRESCALE = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_COMPARE  = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic        cyc;
  logic        tagn_in;
  logic        tagn_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  typedef struct {
    bit          is_read;
    logic [2:0]  idx;
    logic [31:0] data;
    logic        tag;
  } exp_t;

  exp_t sb_q[$];

  wishbone_timer_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .i_ADDR (addr),
    .i_DATA (wdata),
    .o_DATA (rdata),
    .i_WE   (we),
    .i_SEL  (sel),
    .i_STB  (stb),
    .o_ACK  (ack),
    .i_CYC  (cyc),
    .i_TAGN (tagn_in),
    .o_TAGN (tagn_out),
    .o_IRQ  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ACK must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_ack: got ACK with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_xfer++;
        $display("[TB] xfer %0d %s idx=%0d rdata=%h tagn=%b", n_xfer,
                 e.is_read ? "RD" : "WR", e.idx, rdata, tagn_out);
        if (e.is_read) chk("read_data", rdata, e.data);
        chk("tagn", {31'd0, tagn_out}, {31'd0, e.tag});
      end
    end
  end

  // One transfer, called at posedge+1. The request is sampled at the next
  // edge; ACK must be high right after it and low one cycle later.
  task automatic xfer(input bit w, input logic [2:0] idx, input logic [31:0] d,
                      input logic [3:0] s, input logic tag, input logic [31:0] exp);
    exp_t e;
    e.is_read = !w;
    e.idx     = idx;
    e.data    = exp;
    e.tag     = tag;
    sb_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w;
    addr = {27'd0, idx, 2'b00}; wdata = d; sel = s; tagn_in = tag;
    @(posedge clk); #1;
    chk("ack_latency", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_width", {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, idx, d, s, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp);
    xfer(1'b0, idx, 32'd0, 4'h0, 1'b0, exp);
  endtask

  // Expected COUNT on reads every 2 clocks with PRESCALE = 3.
  logic [31:0] ps_exp [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFE,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0000_0000};

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; sel = '0;
    stb = 1'b0; cyc = 1'b0; tagn_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  {31'd0, ack},      32'd0);
    chk("rst_data", rdata,             32'd0);
    chk("rst_tagn", {31'd0, tagn_out}, 32'd0);
    chk("rst_irq",  {31'd0, irq},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a read is being acknowledged
    wr(IDX_COUNT, 32'h0000_0077, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {27'd0, IDX_COUNT, 2'b00};
    sel = 4'h0; tagn_in = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack_before",  {31'd0, ack},      32'd1);
    chk("midrst_data_before", rdata,             32'h0000_0077);
    chk("midrst_tagn_before", {31'd0, tagn_out}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ack",  {31'd0, ack},      32'd0);
    chk("midrst_data", rdata,             32'd0);
    chk("midrst_tagn", {31'd0, tagn_out}, 32'd0);
    chk("midrst_irq",  {31'd0, irq},      32'd0);
    cyc = 1'b0; stb = 1'b0; tagn_in = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(IDX_COUNT, 32'd0);

    // Byte-lane write over the reset value
    wr(IDX_COMPARE, 32'hDEAD_BEEF, 4'b0101);
    rd(IDX_COMPARE, 32'h00AD_00EF);

    // Periodic interrupt: PRESCALE=0, COMPARE=4, auto-clear. CTRL write edge = T.
    wr(IDX_PRESCALE, 32'd0, 4'hF);
    wr(IDX_COMPARE,  32'd4, 4'hF);
    wr(IDX_CTRL,     32'h7, 4'hF);            // returns at T+1
    repeat (3) @(posedge clk);                // T+4
    #1;
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;                       // T+5: 5th tick, COUNT==COMPARE
    chk("irq_at_match", {31'd0, irq}, 32'd1);
    wr(IDX_STATUS, 32'h1, 4'hF);              // clears at T+6
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(IDX_COUNT, 32'd2);                     // sampled at T+8: 4->0,1,2
    wr(IDX_STATUS, 32'h1, 4'hF);              // T+10 is a match tick: set wins
    chk("irq_w1c_collision", {31'd0, irq}, 32'd1);
    rd(IDX_STATUS, 32'h1);
    wr(IDX_CTRL, 32'h6, 4'hF);                // stop, keep IE and MODE
    wr(IDX_STATUS, 32'h1, 4'hF);
    chk("irq_cleared_stopped", {31'd0, irq}, 32'd0);
    rd(IDX_STATUS, 32'h0);

    // Prescale 3, free-run, wrap with COMPARE != 0xFFFFFFFF. CTRL write edge = U.
    wr(IDX_COUNT,    32'hFFFF_FFFD, 4'hF);
    wr(IDX_COMPARE,  32'h0000_0010, 4'hF);
    wr(IDX_PRESCALE, 32'h0000_0003, 4'hF);
    wr(IDX_CTRL,     32'h1, 4'hF);
    for (int i = 0; i < 7; i++) begin
      rd(IDX_COUNT, ps_exp[i]);               // sampled at U+2, U+4, ... U+14
    end
    rd(IDX_STATUS, 32'h0);                    // U+16: no match on wrap
    rd(IDX_COUNT, 32'h1);                     // U+18
    chk("irq_prescale", {31'd0, irq}, 32'd0);

    // COUNT write on a tick edge (U+20)
    wr(IDX_COUNT, 32'h0000_0100, 4'hF);
    rd(IDX_COUNT, 32'h0000_0100);
    wr(IDX_CTRL, 32'h0, 4'hF);

    // Unmapped offsets 0x18 / 0x14
    xfer(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    xfer(1'b0, 3'd6, 32'd0, 4'h0, 1'b1, 32'd0);
    rd(3'd5, 32'd0);
    rd(IDX_CTRL,     32'h0);
    rd(IDX_PRESCALE, 32'h3);
    rd(IDX_COMPARE,  32'h10);
    rd(IDX_STATUS,   32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drain", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
